arm_cpu: RTL and testbench
==========================

Name: arm_cpu

Overview:
- Multi-cycle ARM-style core executing one 32-bit data-processing instruction per pass.
- Instruction word and PC are supplied externally. The block holds a 16x32 register file, a shifter/ALU and the NZCV status register.
- It drives PC-select and data-RAM control outputs toward the surrounding fetch/memory logic.

Parameters:
- none (all widths fixed: 32-bit datapath, 16 registers, 11-bit RAM/PC addresses)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- instr  input  32  current instruction word, latched in DECODE
- ram_data2  input  32  data-RAM read data; ignored in this revision
- PC  input  32  current program counter; informational only
- waiting  output  1  high in WAIT state
- sel_pc  output  2  next-PC select: 00 hold, 01 increment, 10 load dp_pc
- dp_pc  output  11  branch target = datapath_out[10:0]
- ram_w_en1  output  1  instruction-RAM write enable; constant 0
- ram_w_en2  output  1  data-RAM write enable; constant 0 (no memory ops)
- ram_addr2  output  11  datapath_out[10:0]
- ram_in2  output  32  operand-B register value (Rm)
- status_out  output  32  {N,Z,C,V,28'b0}
- datapath_out  output  32  ALU result register C

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to WAIT; status, IR, A, B, S and C registers clear to 0; sel_pc=00.
  - The register file is NOT cleared; contents persist across resets.
- FSM, one state per clock:
  - WAIT: waiting=1.
  - DECODE: IR<=instr.
  - RD_A: A<=R[Rn=IR[19:16]].
  - RD_B: B<=R[Rm=IR[3:0]].
  - RD_S: S<=R[Rs=IR[11:8]].
  - EXEC.
  - WB: at entry, C and flags are latched.
  - WB->WAIT: R[Rd=IR[15:12]]<=C if the opcode writes; sel_pc=01 during WB.
- Latency: datapath_out/status_out are valid after the 6th rising edge following reset release. The register write occurs on the 7th edge.
- Condition field IR[31:28] is not evaluated; every instruction executes.
- Operand2:
  - I=IR[25]=1: imm8=IR[7:0] rotated right by 2*IR[11:8].
  - I=0, IR[4]=0: Rm shifted by imm5=IR[11:7].
  - I=0, IR[4]=1: Rm shifted by S[7:0].
  - Shift type IR[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Amount >=32: LSL/LSR give 0, ASR gives sign fill, ROR uses amount mod 32.
- Opcodes IR[24:21]:
  - 0000 AND, 0001 EOR, 0010 SUB(A-op2), 0011 RSB, 0100 ADD, 1000 TST (flags only), 1010 CMP (flags only), 1100 ORR, 1101 MOV (op2), 1111 MVN.
  - Any other opcode is a NOP: no write, no flag change, C=0.
- Flags update when S=IR[20]=1, or always for TST/CMP:
  - N=result[31]; Z=(result==0).
  - ADD: C=carry-out; V=signed overflow.
  - SUB/CMP/RSB: C=borrow (unsigned minuend < subtrahend); V=signed overflow.
  - Logical ops and MOV/MVN: C=0, V=0.
- Widths: all arithmetic is 32-bit modulo 2^32. R15 is an ordinary register (PC is external).
- Reset mid-instruction aborts it with no register write.

Decomposition:
- Package arm_cpu_pkg: state enum, opcode constants, shift-type constants, flag bit positions (N=31, Z=30, C=29, V=28).
- One sub-module, arm_alu_shifter: purely combinational. Inputs A, B/imm, S, IR fields; outputs result and NZCV.
- Register file and FSM stay in the top level.

Test Plan:
- Preload: for i=0..15 issue MOV Ri,#(i+1) (0xE3A0_i00(i+1) pattern), each with reset then 7 clocks -> Ri=i+1, status 0.
- ADD R0,R0,R0 (0x00900000) -> after 6 clocks datapath_out=2, status=0; then ADDS R1,R1,R0 (0x00911000) -> 4.
- ADDS R1,R1,#8 (0x02911008) with R1=4 -> 12; then ADD R2,R2,R0 LSL R2 (0xE0822210) with R2=3, R0=2 -> 19.
- ADDS R0,R0,R1 -> 14; then CMP R0,R1 (0xE1500001) -> datapath_out=2, status=0, R0 unchanged.
- SUBS R0,R0,R0 (0xE0500000) -> datapath_out=0, status=0x4000_0000.
- After reset, SUB R5,R5,R1 LSR R3 (0xE0455331), R5=6, R1=12, R3=4 -> datapath_out=6, status=0 (reset cleared Z).

Source files
------------

// File: rtl/arm_cpu_pkg.sv
// Shared types and constants for the arm_cpu core: FSM states, opcodes,
// shift types, status flag positions and small decode helpers.
package arm_cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_RD_A,
    S_RD_B,
    S_RD_S,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int unsigned FLAG_N = 31;
  localparam int unsigned FLAG_Z = 30;
  localparam int unsigned FLAG_C = 29;
  localparam int unsigned FLAG_V = 28;

  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD,
      OP_ORR, OP_MOV, OP_MVN: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    return op_writes(op) || (op == OP_TST) || (op == OP_CMP);
  endfunction

  // Zero-amount rotate works because a 32-bit left shift by 32 yields 0.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/arm_alu_shifter.sv
// Combinational operand-2 shifter and ALU producing the result word and
// the NZCV flags that the top level may latch.
module arm_alu_shifter
  import arm_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [7:0]  s_amt,
  input  logic        imm_sel,
  input  logic [3:0]  op,
  input  logic [11:0] shf,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  logic [31:0] op2;
  logic [7:0]  amt;
  logic [32:0] sum;
  logic        c_f;
  logic        v_f;

  always_comb begin
    amt = shf[4] ? s_amt : {3'b000, shf[11:7]};
    op2 = '0;
    if (imm_sel) begin
      op2 = ror32({24'd0, shf[7:0]}, {shf[11:8], 1'b0});
    end else begin
      case (shf[6:5])
        SH_LSL:  op2 = (amt >= 8'd32) ? '0 : (b << amt);
        SH_LSR:  op2 = (amt >= 8'd32) ? '0 : (b >> amt);
        SH_ASR:  op2 = (amt >= 8'd32) ? {32{b[31]}} : $unsigned($signed(b) >>> amt);
        default: op2 = ror32(b, amt[4:0]);
      endcase
    end
  end

  // C is a borrow on subtraction (set when minuend < subtrahend).
  always_comb begin
    result = '0;
    sum    = '0;
    c_f    = 1'b0;
    v_f    = 1'b0;
    case (op)
      OP_AND, OP_TST: result = a & op2;
      OP_EOR:         result = a ^ op2;
      OP_ORR:         result = a | op2;
      OP_MOV:         result = op2;
      OP_MVN:         result = ~op2;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, op2};
        result = sum[31:0];
        c_f    = sum[32];
        v_f    = (a[31] == op2[31]) && (result[31] != a[31]);
      end
      OP_SUB, OP_CMP: begin
        result = a - op2;
        c_f    = a < op2;
        v_f    = (a[31] != op2[31]) && (result[31] != a[31]);
      end
      OP_RSB: begin
        result = op2 - a;
        c_f    = op2 < a;
        v_f    = (op2[31] != a[31]) && (result[31] != op2[31]);
      end
      default: result = '0;
    endcase
    nzcv = {result[31], result == '0, c_f, v_f};
  end

endmodule

// File: rtl/arm_cpu.sv
// Multi-cycle data-processing core: FSM, 16x32 register file, operand
// latches and the NZCV status register around the shifter/ALU.
module arm_cpu
  import arm_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] ram_data2,
  input  logic [31:0] PC,
  output logic        waiting,
  output logic [1:0]  sel_pc,
  output logic [10:0] dp_pc,
  output logic        ram_w_en1,
  output logic        ram_w_en2,
  output logic [10:0] ram_addr2,
  output logic [31:0] ram_in2,
  output logic [31:0] status_out,
  output logic [31:0] datapath_out
);

  state_t      state, state_nx;
  logic [31:0] rf [16];
  logic [31:0] ir, a_r, b_r, s_r, c_r;
  logic [3:0]  flags;
  logic [31:0] alu_res;
  logic [3:0]  alu_nzcv;
  logic [3:0]  op;
  logic        flag_en;
  logic        unused_ok;

  assign op        = ir[24:21];
  assign flag_en   = op_valid(op) && (ir[20] || op == OP_TST || op == OP_CMP);
  assign unused_ok = ^{ram_data2, PC, ir[31:26], s_r[31:8]};

  arm_alu_shifter u_alu (
    .a      (a_r),
    .b      (b_r),
    .s_amt  (s_r[7:0]),
    .imm_sel(ir[25]),
    .op     (op),
    .shf    (ir[11:0]),
    .result (alu_res),
    .nzcv   (alu_nzcv)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:   state_nx = S_DECODE;
      S_DECODE: state_nx = S_RD_A;
      S_RD_A:   state_nx = S_RD_B;
      S_RD_B:   state_nx = S_RD_S;
      S_RD_S:   state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB;
      S_WB:     state_nx = S_WAIT;
      default:  state_nx = S_WAIT;
    endcase
  end

  always_comb begin
    waiting = (state == S_WAIT);
    sel_pc  = (state == S_WB) ? 2'b01 : 2'b00;
  end

  // C and flags are captured on the EXEC->WB edge; NOPs still load C with 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir    <= '0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      c_r   <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_DECODE: ir  <= instr;
        S_RD_A:   a_r <= rf[ir[19:16]];
        S_RD_B:   b_r <= rf[ir[3:0]];
        S_RD_S:   s_r <= rf[ir[11:8]];
        S_EXEC: begin
          c_r <= alu_res;
          if (flag_en) flags <= alu_nzcv;
        end
        default: ;
      endcase
    end
  end

  // Register file has no reset; an asserted reset suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_WB && op_writes(op)) rf[ir[15:12]] <= c_r;
  end

  always_comb begin
    status_out         = '0;
    status_out[FLAG_N] = flags[3];
    status_out[FLAG_Z] = flags[2];
    status_out[FLAG_C] = flags[1];
    status_out[FLAG_V] = flags[0];
  end

  assign datapath_out = c_r;
  assign dp_pc        = c_r[10:0];
  assign ram_addr2    = c_r[10:0];
  assign ram_in2      = b_r;
  assign ram_w_en1    = 1'b0;
  assign ram_w_en2    = 1'b0;

endmodule

// File: tb/tb_arm_cpu.sv
// Bench for arm_cpu: directed instructions, a register-level model of the
// instruction set, and a per-cycle compare of all outputs.
module tb_arm_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, ram_data2, pc;
  logic        waiting, ram_w_en1, ram_w_en2;
  logic [1:0]  sel_pc;
  logic [10:0] dp_pc, ram_addr2;
  logic [31:0] ram_in2, status_out, datapath_out;

  int          cyc = -1;
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_res, exp_st, exp_rm;
  bit          rm_ok;
  logic [31:0] m_r [16];
  bit          m_known [16];

  arm_cpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .ram_data2   (ram_data2),
    .PC          (pc),
    .waiting     (waiting),
    .sel_pc      (sel_pc),
    .dp_pc       (dp_pc),
    .ram_w_en1   (ram_w_en1),
    .ram_w_en2   (ram_w_en2),
    .ram_addr2   (ram_addr2),
    .ram_in2     (ram_in2),
    .status_out  (status_out),
    .datapath_out(datapath_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d instr=%h got=%h want=%h", nm, cyc, instr, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    r = v;
    for (int unsigned i = 0; i < n; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] m_op2(input logic [31:0] w);
    logic [31:0] rm;
    int unsigned amt;
    if (w[25]) return rotr({24'd0, w[7:0]}, 2 * int'(w[11:8]));
    rm  = m_r[w[3:0]];
    amt = w[4] ? int'(m_r[w[11:8]][7:0]) : int'(w[11:7]);
    case (w[6:5])
      2'd0:    return (amt >= 32) ? 32'd0 : (rm << amt);
      2'd1:    return (amt >= 32) ? 32'd0 : (rm >> amt);
      2'd2:    return (amt >= 32) ? (rm[31] ? 32'hFFFF_FFFF : 32'd0)
                                  : $unsigned($signed(rm) >>> amt);
      default: return rotr(rm, amt % 32);
    endcase
  endfunction

  task automatic model(input logic [31:0] w, output logic [31:0] res,
                       output logic [31:0] st, output bit wr);
    logic [3:0]  op;
    logic [31:0] a, b;
    longint      ua, ub, sa, sb, t;
    bit          c, v, valid, setf;
    op = w[24:21];
    a  = m_r[w[19:16]];
    b  = m_op2(w);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0; v = 0; valid = 1; res = '0;
    case (op)
      4'h0, 4'h8: res = a & b;
      4'h1:       res = a ^ b;
      4'hC:       res = a | b;
      4'hD:       res = b;
      4'hF:       res = ~b;
      4'h4: begin
        t = ua + ub; res = t[31:0]; c = (t > 64'hFFFF_FFFF);
        t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'h2, 4'hA: begin
        t = ua - ub; res = t[31:0]; c = (ua < ub);
        t = sa - sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'h3: begin
        t = ub - ua; res = t[31:0]; c = (ub < ua);
        t = sb - sa; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      default: begin valid = 0; res = '0; end
    endcase
    wr   = valid && op != 4'h8 && op != 4'hA;
    setf = valid && (w[20] || op == 4'h8 || op == 4'hA);
    // Every instruction starts from a fresh reset, so un-set flags read 0.
    st   = setf ? {res[31], res == 32'd0, c, v, 28'd0} : 32'd0;
  endtask

  always @(negedge clk) begin
    if (cyc >= 0) begin
      chk("waiting", {31'd0, waiting}, (cyc == 0 || cyc == 7) ? 32'd1 : 32'd0);
      chk("sel_pc", {30'd0, sel_pc}, (cyc == 6) ? 32'd1 : 32'd0);
      chk("datapath_out", datapath_out, (cyc >= 6) ? exp_res : 32'd0);
      chk("status_out", status_out, (cyc >= 6) ? exp_st : 32'd0);
      chk("dp_pc", {21'd0, dp_pc}, (cyc >= 6) ? {21'd0, exp_res[10:0]} : 32'd0);
      chk("ram_addr2", {21'd0, ram_addr2}, (cyc >= 6) ? {21'd0, exp_res[10:0]} : 32'd0);
      chk("ram_w_en", {30'd0, ram_w_en1, ram_w_en2}, 32'd0);
      if (cyc < 4)     chk("ram_in2", ram_in2, 32'd0);
      else if (rm_ok)  chk("ram_in2", ram_in2, exp_rm);
    end
  end

  task automatic run(input logic [31:0] w, input int unsigned edges, input bit lit_en,
                     input logic [31:0] lit_res, input logic [31:0] lit_st);
    logic [31:0] r, s;
    bit wr;
    model(w, r, s, wr);
    exp_res = r;
    exp_st  = s;
    exp_rm  = m_r[w[3:0]];
    rm_ok   = m_known[w[3:0]];
    instr   = w;
    rst_n   = 1'b0;
    cyc     = -1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc   = 0;
    repeat (edges) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    @(negedge clk); #1;
    if (lit_en) begin
      chk("model_pin_res", exp_res, lit_res);
      chk("model_pin_st", exp_st, lit_st);
      chk("lit_result", datapath_out, lit_res);
      chk("lit_status", status_out, lit_st);
    end
    if (edges == 7 && wr) begin
      m_r[w[15:12]]     = r;
      m_known[w[15:12]] = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; ram_data2 = 32'hDEAD_BEEF; pc = '0;
    for (int i = 0; i < 16; i++)
      run(32'hE3A0_0000 | (32'(i) << 12) | 32'(i + 1), 7, 1'b1, 32'(i + 1), 32'h0);
    run(32'h0090_0000, 7, 1'b1, 32'd2,  32'h0);          // ADDS R0,R0,R0
    run(32'h0091_1000, 7, 1'b1, 32'd4,  32'h0);          // ADDS R1,R1,R0
    run(32'h0291_1008, 7, 1'b1, 32'd12, 32'h0);          // ADDS R1,R1,#8
    run(32'hE082_2210, 7, 1'b1, 32'd19, 32'h0);          // ADD R2,R2,R0 LSL R2
    run(32'hE090_0001, 7, 1'b1, 32'd14, 32'h0);          // ADDS R0,R0,R1
    run(32'hE150_0001, 7, 1'b1, 32'd2,  32'h0);          // CMP R0,R1
    run(32'hE350_0000, 7, 1'b1, 32'd14, 32'h0);          // CMP R0,#0 readback
    run(32'hE050_0000, 7, 1'b1, 32'd0,  32'h4000_0000);  // SUBS R0,R0,R0
    run(32'hE045_5331, 7, 1'b1, 32'd6,  32'h0);          // SUB R5,R5,R1 LSR R3
    run(32'hE3E0_6000, 7, 1'b1, 32'hFFFF_FFFF, 32'h0);          // MVN R6,#0
    run(32'hE3F0_7000, 7, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);  // MVNS R7,#0
    run(32'hE3A0_9028, 7, 1'b1, 32'd40, 32'h0);                 // MOV R9,#40
    run(32'hE1B0_8956, 7, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);  // MOVS R8,R6 ASR R9
    run(32'hE1B0_A916, 7, 1'b1, 32'd0, 32'h4000_0000);          // MOVS R10,R6 LSL R9
    run(32'hE1A0_B97F, 7, 1'b1, 32'h1000_0000, 32'h0);          // MOV R11,R15 ROR R9
    run(32'hE3A0_C4FF, 7, 1'b1, 32'hFF00_0000, 32'h0);          // MOV R12,#0xFF ror 8
    run(32'hE096_D006, 7, 1'b1, 32'hFFFF_FFFE, 32'hA000_0000);  // ADDS R13,R6,R6
    run(32'hE3A0_E102, 7, 1'b1, 32'h8000_0000, 32'h0);          // MOV R14,#0x80000000
    run(32'hE25E_0001, 7, 1'b1, 32'h7FFF_FFFF, 32'h1000_0000);  // SUBS R0,R14,#1
    run(32'hE271_1000, 7, 1'b1, 32'hFFFF_FFF4, 32'hA000_0000);  // RSBS R1,R1,#0
    run(32'hE302_0004, 7, 1'b1, 32'd0, 32'h4000_0000);          // TST R2,#4 (S=0)
    run(32'hE0D2_1002, 7, 1'b1, 32'd0, 32'h0);                  // unsupported opcode
    run(32'hE1B0_3FA6, 7, 1'b1, 32'd1, 32'h0);                  // MOVS R3,R6 LSR #31
    run(32'hE3A0_4077, 5, 1'b0, 32'd0, 32'h0);                  // MOV R4 aborted by reset
    run(32'hE354_0000, 7, 1'b1, 32'd5, 32'h0);                  // CMP R4,#0
    run(32'hE351_0000, 7, 1'b1, 32'hFFFF_FFF4, 32'h8000_0000);  // CMP R1,#0
    run(32'hE352_0000, 7, 1'b1, 32'd19, 32'h0);                 // CMP R2,#0
    run(32'hE350_0000, 7, 1'b1, 32'h7FFF_FFFF, 32'h0);          // CMP R0,#0
    run(32'hE355_0000, 7, 1'b1, 32'd6, 32'h0);                  // CMP R5,#0
    cyc = -1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
